sp_frame_tx: RTL

// - Host-side transmitter/collector for the 9-sample series processor: buffers 9 signed samples, sends them as one in_valid frame with mode, then collects the 3-beat max/median/min response.
// - Applies the Gray encoding that the processor decodes when mode[0]=1. One frame in flight at a time.

---
 rtl/sp_frame_tx.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sp_frame_tx.sv
// ---------------------------------------------------------------------------
// sp_frame_tx
// Host-side transmitter/collector for the 9-sample series processor.
// Buffers NS signed samples and sends them as one in_valid frame together
// with the frame mode. When mode bit 0 is set, each sample is Gray-encoded
// as sign + Gray(|v|). The block then collects the 3-beat max/median/min
// response. Only one frame is in flight at a time.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/
//   wr_data            sample buffer write port (slots 0..NS-1, others dropped)
//   start, cfg_mode    launch-frame pulse and mode for that frame
//   busy               high from start acceptance through the res_valid cycle
//   sp_in_valid/data/
//   sp_in_mode         frame beats towards the processor
//   sp_out_valid/data  response beats from the processor
//   res_valid, res_err one-cycle result pulse, error flag qualified by it
//   res_max/med/min    captured response beats 1/2/3, held until next start
// ---------------------------------------------------------------------------
module sp_frame_tx #(
  parameter int NS     = 9,
  parameter int DW     = 9,
  parameter int TO_CYC = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [2:0]    cfg_mode,
  output logic          busy,
  output logic          sp_in_valid,
  output logic [DW-1:0] sp_in_data,
  output logic [2:0]    sp_in_mode,
  input  logic          sp_out_valid,
  input  logic [DW:0]   sp_out_data,
  output logic          res_valid,
  output logic          res_err,
  output logic [DW:0]   res_max,
  output logic [DW:0]   res_med,
  output logic [DW:0]   res_min
);

  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [3:0]    NS_L      = 4'(NS);
  localparam logic [3:0]    LAST_IDX  = 4'(NS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_RECV = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_buf [NS];
  logic [3:0]    r_idx;
  logic [2:0]    r_mode_q;
  logic [TW-1:0] r_tmo;
  logic          r_second;     // 1 once beat 2 has been captured in RECV

  logic [DW-1:0] w_sample;
  logic [DW-1:0] w_beat;
  logic [DW-1:0] w_beat0;
  logic          w_wr_ok;

  // Sign + Gray code of the magnitude; the 8-bit wrap makes -256 map to {1,0}.
  function automatic logic [DW-1:0] gray_enc(input logic [DW-1:0] v);
    logic            s;
    logic [DW-2:0]   mag;
    s   = v[DW-1];
    mag = s ? (~v[DW-2:0] + {{(DW-2){1'b0}}, 1'b1}) : v[DW-2:0];
    return {s, mag ^ (mag >> 1)};
  endfunction

  // Beat selection: current slot during SEND, slot 0 for the start edge.
  always_comb begin
    w_sample = '0;
    if (r_idx <= LAST_IDX) begin
      w_sample = r_buf[r_idx];
    end else begin
      w_sample = '0;
    end
    w_beat  = r_mode_q[0] ? gray_enc(w_sample) : w_sample;
    w_beat0 = cfg_mode[0] ? gray_enc(r_buf[0]) : r_buf[0];
    w_wr_ok = (r_state == S_IDLE) && !start && wr_en && (wr_addr < NS_L);
  end

  // Sample buffer: written only while idle and no start is being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_mode_q    <= 3'd0;
      r_tmo       <= '0;
      r_second    <= 1'b0;
      busy        <= 1'b0;
      sp_in_valid <= 1'b0;
      sp_in_data  <= '0;
      sp_in_mode  <= 3'd0;
      res_valid   <= 1'b0;
      res_err     <= 1'b0;
      res_max     <= '0;
      res_med     <= '0;
      res_min     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          res_valid <= 1'b0;
          if (start) begin
            // Beat 0 goes out on the acceptance edge so beats occupy t+1..t+NS.
            r_mode_q    <= cfg_mode;
            res_max     <= '0;
            res_med     <= '0;
            res_min     <= '0;
            res_err     <= 1'b0;
            busy        <= 1'b1;
            sp_in_valid <= 1'b1;
            sp_in_data  <= w_beat0;
            sp_in_mode  <= cfg_mode;
            r_idx       <= 4'd1;
            r_state     <= S_SEND;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_SEND: begin
          if (r_idx <= LAST_IDX) begin
            sp_in_valid <= 1'b1;
            sp_in_data  <= w_beat;
            sp_in_mode  <= r_mode_q;
            r_idx       <= r_idx + 4'd1;
          end else begin
            sp_in_valid <= 1'b0;
            sp_in_data  <= '0;
            sp_in_mode  <= 3'd0;
            r_tmo       <= '0;
            r_second    <= 1'b0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          r_tmo <= r_tmo + TMO_ONE;
          if (sp_out_valid) begin
            res_max <= sp_out_data;
          end else begin
            res_max <= res_max;
          end
          // Timeout wins over moving on: the frame would already be late.
          if (r_tmo == TMO_LAST) begin
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (sp_out_valid) begin
            r_state <= S_RECV;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_RECV: begin
          r_tmo <= r_tmo + TMO_ONE;
          if (!sp_out_valid) begin
            // Response beats must be back-to-back; a gap breaks the frame.
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            r_state   <= S_DONE;
          end else if (!r_second) begin
            res_med  <= sp_out_data;
            r_second <= 1'b1;
            if (r_tmo == TMO_LAST) begin
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_RECV;
            end
          end else begin
            // Third beat completes the frame.
            res_min   <= sp_out_data;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          busy        <= 1'b0;
          sp_in_valid <= 1'b0;
          sp_in_data  <= '0;
          sp_in_mode  <= 3'd0;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
